// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped branch target buffer with saturating counters and statistics
module branch_predictor #(
  parameter int ENTRIES = 64,
  parameter int CTR_W   = 2,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 16,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       lookup_pc_i,
  output logic              predict_taken_o,
  output logic [31:0]       predict_target_o,
  input  logic              upd_valid_i,
  input  logic [31:0]       upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [31:0]       upd_target_i,
  input  logic              upd_pred_taken_i,
  input  logic [31:0]       upd_pred_target_i,
  input  logic              flush_i,
  output logic              mispredict_o,
  output logic [CNT_W-1:0]  branch_cnt_o,
  output logic [CNT_W-1:0]  mispred_cnt_o
);

  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1 << (CTR_W - 1));

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q    [ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit;
  logic             up_write;
  logic             mis_cond;
  logic             unused_pc_bits;

  assign lk_idx = lookup_pc_i[IDX_W+1:2];
  assign lk_tag = lookup_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign up_idx = upd_pc_i[IDX_W+1:2];
  assign up_tag = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];

  // Bits outside index/tag fields are intentionally ignored
  assign unused_pc_bits = ^{lookup_pc_i, upd_pc_i};

  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // A flush in the same cycle suppresses every table modification
  assign up_write = upd_valid_i && !flush_i;

  assign mis_cond = (upd_pred_taken_i != upd_taken_i) ||
                    (upd_taken_i && upd_pred_taken_i && (upd_pred_target_i != upd_target_i));

  // Lookup reads the pre-edge table contents, so same-cycle updates show up one cycle later
  always_comb begin
    predict_taken_o  = lk_hit && ctr_q[lk_idx][CTR_W-1];
    predict_target_o = predict_taken_o ? target_q[lk_idx] : lookup_pc_i + 32'd4;
  end

  // Valid bits: cleared by reset or flush, set on allocation of a taken miss
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (upd_valid_i && !up_hit && upd_taken_i) begin
      valid_q[up_idx] <= 1'b1;
    end
  end

  // Saturating direction counters: train on hits, start weakly taken on allocation
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ctr_q <= '{default: '0};
    end else if (up_write) begin
      if (up_hit) begin
        if (upd_taken_i) begin
          if (ctr_q[up_idx] != CTR_MAX) ctr_q[up_idx] <= ctr_q[up_idx] + CTR_W'(1);
        end else begin
          if (ctr_q[up_idx] != '0) ctr_q[up_idx] <= ctr_q[up_idx] - CTR_W'(1);
        end
      end else if (upd_taken_i) begin
        ctr_q[up_idx] <= CTR_WEAK;
      end
    end
  end

  // Tags and targets need no reset since valid bits gate their use
  always_ff @(posedge clk_i) begin
    if (rst_i && up_write && upd_taken_i) begin
      target_q[up_idx] <= upd_target_i;
      if (!up_hit) tag_q[up_idx] <= up_tag;
    end
  end

  // Registered mispredict pulse and saturating statistics, independent of flush
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mispredict_o  <= 1'b0;
      branch_cnt_o  <= '0;
      mispred_cnt_o <= '0;
    end else begin
      mispredict_o <= upd_valid_i && mis_cond;
      if (upd_valid_i && (branch_cnt_o != '1)) branch_cnt_o <= branch_cnt_o + CNT_W'(1);
      if (upd_valid_i && mis_cond && (mispred_cnt_o != '1)) mispred_cnt_o <= mispred_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - scoreboard bench for branch_predictor
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] lookup_pc = 32'h0;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = 32'h0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = 32'h0;
  logic        upd_pred_taken = 1'b0;
  logic [31:0] upd_pred_target = 32'h0;
  logic        flush = 1'b0;

  logic        predict_taken, mispredict;
  logic [31:0] predict_target;
  logic [15:0] branch_cnt, mispred_cnt;

  logic        s_predict_taken, s_mispredict;
  logic [31:0] s_predict_target;
  logic [3:0]  s_branch_cnt, s_mispred_cnt;

  int n_cmp = 0;
  int n_err = 0;

  branch_predictor dut (
    .clk_i(clk), .rst_i(rst), .lookup_pc_i(lookup_pc),
    .predict_taken_o(predict_taken), .predict_target_o(predict_target),
    .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
    .upd_target_i(upd_target), .upd_pred_taken_i(upd_pred_taken),
    .upd_pred_target_i(upd_pred_target), .flush_i(flush),
    .mispredict_o(mispredict), .branch_cnt_o(branch_cnt), .mispred_cnt_o(mispred_cnt)
  );

  branch_predictor #(.CNT_W(4)) u_sat (
    .clk_i(clk), .rst_i(rst), .lookup_pc_i(lookup_pc),
    .predict_taken_o(s_predict_taken), .predict_target_o(s_predict_target),
    .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
    .upd_target_i(upd_target), .upd_pred_taken_i(upd_pred_taken),
    .upd_pred_target_i(upd_pred_target), .flush_i(flush),
    .mispredict_o(s_mispredict), .branch_cnt_o(s_branch_cnt), .mispred_cnt_o(s_mispred_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Reference table (ENTRIES=64, TAG_W=8, CTR_W=2)
  bit        m_valid [64];
  bit [7:0]  m_tag   [64];
  bit [31:0] m_tgt   [64];
  int        m_ctr   [64];
  bit [15:0] m_b, m_m;
  bit [3:0]  m_sb, m_sm;

  typedef struct {
    bit        mis;
    bit [15:0] b;
    bit [15:0] m;
    bit [3:0]  sb;
    bit [3:0]  sm;
  } exp_t;
  exp_t sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 0;
      m_ctr[i] = 0;
    end
    m_b = 0; m_m = 0; m_sb = 0; m_sm = 0;
  endfunction

  function automatic void m_predict(input bit [31:0] pc, output bit tk, output bit [31:0] tg);
    int idx = int'(pc[7:2]);
    bit hit = m_valid[idx] && (m_tag[idx] == pc[15:8]);
    tk = hit && (m_ctr[idx] >= 2);
    tg = tk ? m_tgt[idx] : pc + 32'd4;
  endfunction

  function automatic void m_table(input bit [31:0] pc, input bit tk, input bit [31:0] tg, input bit fl);
    int idx = int'(pc[7:2]);
    bit hit = m_valid[idx] && (m_tag[idx] == pc[15:8]);
    if (fl) begin
      for (int i = 0; i < 64; i++) m_valid[i] = 0;
    end else if (hit) begin
      if (tk) begin
        if (m_ctr[idx] < 3) m_ctr[idx]++;
        m_tgt[idx] = tg;
      end else if (m_ctr[idx] > 0) begin
        m_ctr[idx]--;
      end
    end else if (tk) begin
      m_valid[idx] = 1; m_tag[idx] = pc[15:8]; m_tgt[idx] = tg; m_ctr[idx] = 2;
    end
  endfunction

  task automatic lk_chk(input string tag);
    bit tk;
    bit [31:0] tg;
    m_predict(lookup_pc, tk, tg);
    #1;
    chk({tag, "_taken"}, 32'(predict_taken), 32'(tk));
    chk({tag, "_target"}, predict_target, tg);
  endtask

  // Drive one update; lookup is checked against pre-update state before the edge and post-update after
  task automatic update(input string tag, input bit [31:0] pc, input bit tk, input bit [31:0] tg,
                        input bit ptk, input bit [31:0] ptg, input bit fl);
    exp_t e;
    upd_valid = 1; upd_pc = pc; upd_taken = tk; upd_target = tg;
    upd_pred_taken = ptk; upd_pred_target = ptg; flush = fl;
    e.mis = (ptk != tk) || (tk && ptk && (ptg != tg));
    if (m_b != 16'hffff) m_b++;
    if (m_sb != 4'hf) m_sb++;
    if (e.mis && m_m != 16'hffff) m_m++;
    if (e.mis && m_sm != 4'hf) m_sm++;
    e.b = m_b; e.m = m_m; e.sb = m_sb; e.sm = m_sm;
    sb_q.push_back(e);
    lk_chk({tag, "_pre"});
    @(posedge clk);
    m_table(pc, tk, tg, fl);
    #1;
    upd_valid = 0; flush = 0;
    e = sb_q.pop_front();
    chk({tag, "_mispredict"}, 32'(mispredict), 32'(e.mis));
    chk({tag, "_branch_cnt"}, 32'(branch_cnt), 32'(e.b));
    chk({tag, "_mispred_cnt"}, 32'(mispred_cnt), 32'(e.m));
    chk({tag, "_sat_branch_cnt"}, 32'(s_branch_cnt), 32'(e.sb));
    chk({tag, "_sat_mispred_cnt"}, 32'(s_mispred_cnt), 32'(e.sm));
    lk_chk({tag, "_post"});
  endtask

  task automatic idle(input string tag);
    @(posedge clk);
    #1;
    chk({tag, "_mispredict_idle"}, 32'(mispredict), 32'd0);
  endtask

  initial begin
    bit tk;
    bit [31:0] tg;

    // Reset state
    m_reset();
    lookup_pc = 32'h40;
    #2;
    chk("rst_taken", 32'(predict_taken), 32'd0);
    chk("rst_target", predict_target, 32'h44);
    chk("rst_branch_cnt", 32'(branch_cnt), 32'd0);
    chk("rst_mispred_cnt", 32'(mispred_cnt), 32'd0);
    chk("rst_mispredict", 32'(mispredict), 32'd0);
    @(posedge clk); #1;
    rst = 1;

    // Allocation on taken miss, mispredicted as not-taken
    update("alloc", 32'h40, 1, 32'h100, 0, 32'h44, 0);
    chk("alloc_mis_const", 32'(mispredict), 32'd1);
    chk("alloc_mcnt_const", 32'(mispred_cnt), 32'd1);
    chk("alloc_taken_const", 32'(predict_taken), 32'd1);
    chk("alloc_target_const", predict_target, 32'h100);
    idle("alloc");

    // Four not-taken updates drive the counter to zero without underflow
    for (int i = 0; i < 4; i++) begin
      m_predict(32'h40, tk, tg);
      update($sformatf("nt%0d", i), 32'h40, 0, 32'h0, tk, tg, 0);
      chk($sformatf("nt%0d_taken_const", i), 32'(predict_taken), 32'd0);
    end
    m_predict(32'h40, tk, tg);
    update("ret1", 32'h40, 1, 32'h100, tk, tg, 0);
    chk("ret1_still_nt", 32'(predict_taken), 32'd0);
    m_predict(32'h40, tk, tg);
    update("ret2", 32'h40, 1, 32'h104, tk, tg, 0);
    chk("ret2_taken_const", 32'(predict_taken), 32'd1);
    chk("ret2_target_const", predict_target, 32'h104);

    // Aliasing: same index, different tag
    lookup_pc = 32'h140;
    update("alias", 32'h140, 1, 32'h200, 0, 32'h144, 0);
    chk("alias_new_target", predict_target, 32'h200);
    lookup_pc = 32'h40;
    lk_chk("alias_old_miss");
    chk("alias_old_target_const", predict_target, 32'h44);

    // Same-cycle update and lookup: pre/post checks inside update cover old/new visibility
    lookup_pc = 32'h140;
    update("same", 32'h140, 0, 32'h0, 1, 32'h200, 0);
    chk("same_post_nt", 32'(predict_taken), 32'd0);

    // Taken with wrong predicted target counts as a mispredict
    update("tgt_a", 32'h144, 1, 32'h300, 0, 32'h148, 0);
    lookup_pc = 32'h144;
    update("tgt_b", 32'h144, 1, 32'h304, 1, 32'h300, 0);
    chk("tgt_b_mis_const", 32'(mispredict), 32'd1);
    update("tgt_c", 32'h144, 1, 32'h304, 1, 32'h304, 0);
    chk("tgt_c_mis_const", 32'(mispredict), 32'd0);

    // Flush together with a taken miss: no allocation, statistics still count
    update("pre_flush", 32'h80, 1, 32'h400, 0, 32'h84, 0);
    update("flush", 32'h180, 1, 32'h500, 0, 32'h184, 1);
    lookup_pc = 32'h180; lk_chk("flush_miss_180");
    chk("flush_180_const", 32'(predict_taken), 32'd0);
    lookup_pc = 32'h80;  lk_chk("flush_miss_80");
    lookup_pc = 32'h144; lk_chk("flush_miss_144");
    idle("flush");

    // Asynchronous reset mid-cycle discards an in-flight update
    update("pre_rst", 32'h40, 1, 32'h600, 0, 32'h44, 0);
    upd_valid = 1; upd_pc = 32'h40; upd_taken = 1; upd_target = 32'h700;
    upd_pred_taken = 0; upd_pred_target = 32'h44;
    rst = 0;
    m_reset();
    #1;
    chk("arst_branch_cnt", 32'(branch_cnt), 32'd0);
    chk("arst_mispred_cnt", 32'(mispred_cnt), 32'd0);
    chk("arst_mispredict", 32'(mispredict), 32'd0);
    lookup_pc = 32'h40; lk_chk("arst_lookup");
    @(posedge clk); #1;
    upd_valid = 0;
    rst = 1;
    lk_chk("arst_discarded");
    idle("arst");

    // Saturation of 4-bit statistics after 2^4+3 updates
    for (int i = 0; i < 19; i++) begin
      update($sformatf("sat%0d", i), 32'h800 + 32'(i * 4), 0, 32'h0, 1, 32'h900, 0);
    end
    chk("sat_branch_cnt_const", 32'(s_branch_cnt), 32'd15);
    chk("sat_mispred_cnt_const", 32'(s_mispred_cnt), 32'd15);
    chk("wide_branch_cnt_const", 32'(branch_cnt), 32'd19);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
